// File: rtl/clk_gen_pkg.sv
// ============================================================================
// Module      : clk_gen_pkg
// Description : Shared defaults and channel state encoding for clk_gen_multi.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_gen_pkg;

    localparam int NCH_DEF = 4;
    localparam int W_DEF   = 16;
    localparam int P_MIN   = 2;
    localparam int H_RESET = 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

endpackage

`default_nettype wire

// File: rtl/clk_gen_chan.sv
// ============================================================================
// Module      : clk_gen_chan
// Description : One programmable clock divider channel with shadowed
//               period/high-time; optional sync input under
//               CLK_GEN_PHASE_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_gen_chan
    import clk_gen_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] period,
    input  logic [W-1:0] high,
`ifdef CLK_GEN_PHASE_SYNC_EN
    input  logic         sync,
`endif
    output logic         clk_out,
    output logic         tick
);

    chan_state_t  r_state;
    chan_state_t  w_state_nxt;
    logic [W-1:0] r_cnt,  w_cnt_nxt;
    logic [W-1:0] r_pa,   w_pa_nxt;
    logic [W-1:0] r_ha,   w_ha_nxt;
    logic [W-1:0] r_ps,   r_hs;
    logic         r_pend, w_pend_nxt;
    logic         r_clk_out, r_tick;
    logic [W-1:0] w_ps_eff, w_hs_eff, w_pa_new, w_ha_new;
    logic         w_wrap, w_realign, w_run_nxt;

`ifdef CLK_GEN_PHASE_SYNC_EN
    assign w_realign = sync;
`else
    assign w_realign = 1'b0;
`endif

    // A load in the current cycle is visible to any copy made at this edge.
    assign w_ps_eff = load ? period : r_ps;
    assign w_hs_eff = load ? high   : r_hs;
    assign w_pa_new = (w_ps_eff < W'(P_MIN)) ? W'(P_MIN) : w_ps_eff;
    assign w_ha_new = (w_hs_eff > w_pa_new) ? w_pa_new : w_hs_eff;
    assign w_wrap   = (r_cnt == r_pa - W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pa_nxt    = r_pa;
        w_ha_nxt    = r_ha;
        w_pend_nxt  = r_pend;
        case (r_state)
            IDLE: begin
                w_cnt_nxt  = '0;
                w_pa_nxt   = w_pa_new;
                w_ha_nxt   = w_ha_new;
                w_pend_nxt = 1'b0;
                if (en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_pa_nxt    = w_pa_new;
                    w_ha_nxt    = w_ha_new;
                    w_pend_nxt  = 1'b0;
                end else if (w_wrap || w_realign) begin
                    // Shadow is only promoted at a period boundary: no runt pulses.
                    w_cnt_nxt  = '0;
                    w_pend_nxt = 1'b0;
                    if (r_pend || load) begin
                        w_pa_nxt = w_pa_new;
                        w_ha_nxt = w_ha_new;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + W'(1);
                    if (load) begin
                        w_pend_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_run_nxt = (w_state_nxt == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pa      <= W'(P_MIN);
            r_ha      <= W'(H_RESET);
            r_ps      <= W'(P_MIN);
            r_hs      <= W'(H_RESET);
            r_pend    <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pa      <= w_pa_nxt;
            r_ha      <= w_ha_nxt;
            r_ps      <= w_ps_eff;
            r_hs      <= w_hs_eff;
            r_pend    <= w_pend_nxt;
            r_clk_out <= w_run_nxt && (w_cnt_nxt < w_ha_nxt);
            r_tick    <= w_run_nxt && (w_cnt_nxt == w_pa_nxt - W'(1));
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule

`default_nettype wire

// File: rtl/clk_gen_multi.sv
// ============================================================================
// Module      : clk_gen_multi
// Description : NCH independent programmable clock dividers. Defining
//               CLK_GEN_PHASE_SYNC_EN adds a sync input that realigns all
//               running channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   load,
    input  logic [NCH*W-1:0] period,
    input  logic [NCH*W-1:0] high,
`ifdef CLK_GEN_PHASE_SYNC_EN
    input  logic             sync,
`endif
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_gen_chan #(
            .W(W)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en[i]),
            .load   (load[i]),
            .period (period[i*W +: W]),
            .high   (high[i*W +: W]),
`ifdef CLK_GEN_PHASE_SYNC_EN
            .sync   (sync),
`endif
            .clk_out(clk_out[i]),
            .tick   (tick[i])
        );
    end

endmodule

`default_nettype wire

// File: doc/clk_gen_multi.md
CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter W, default 16, meaning the width of period and high-time fields.
REQ-003 Port clk  input  1  board clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port en  input  NCH  per-channel run enable.
REQ-006 Port load  input  NCH  per-channel one-cycle strobe that captures period/high into the channel's shadow registers.
REQ-007 Port period  input  NCH*W  per-channel full period in clk cycles; channel i uses bits [i*W +: W].
REQ-008 Port high  input  NCH*W  per-channel high time in clk cycles; channel i uses bits [i*W +: W].
REQ-009 Port clk_out  output  NCH  per-channel registered divided clock.
REQ-010 Port tick  output  NCH  per-channel one-cycle pulse on the last cycle of each period.

Function
REQ-011 Each channel SHALL hold an active pair (P_a, H_a), a shadow pair (P_s, H_s), a pending flag and a W-bit counter cnt.
REQ-012 Each channel SHALL have the states IDLE (en=0) and RUN (en=1).
REQ-013 In IDLE: cnt=0, clk_out=0, tick=0, and (P_a, H_a) are copied from the shadow every cycle.
REQ-014 IDLE->RUN on en sampled high: the first RUN cycle has cnt=0.
REQ-015 In RUN, cnt SHALL increment each cycle and wrap from P_a-1 to 0.
REQ-016 clk_out SHALL be registered and high exactly for cnt in 0..H_a-1; latency from en sampled high to first clk_out high is 1 cycle.
REQ-017 tick SHALL be 1 exactly in the cycle where cnt==P_a-1.
REQ-018 Odd P_a SHALL be supported: P=5, H=2 gives 2 cycles high and 3 cycles low; no half-cycle edges.
REQ-019 An effective period below 2 SHALL be clamped to 2 when copied into P_a.
REQ-020 H_a SHALL be clamped to P_a: H=0 gives clk_out constant 0, H>=P gives clk_out constant 1; tick continues in both cases.
REQ-021 load in RUN SHALL update the shadow and set pending; the shadow SHALL be copied to active only at wrap (cnt==P_a-1 -> 0), so no runt pulse is produced.
REQ-022 Multiple loads before a wrap: the last one SHALL win.
REQ-023 load in the same cycle as wrap SHALL take effect at that wrap.
REQ-024 RUN->IDLE on en low: clk_out and tick SHALL be 0 in the next cycle, with no completion of the period.
REQ-025 Channels SHALL be fully independent; there is no cross-channel interaction except REQ-031.

Reset
REQ-026 While rst_n=0: clk_out=0, tick=0, cnt=0, pending=0.
REQ-027 While rst_n=0: P_s=P_a=2 and H_s=H_a=1.
REQ-028 Reset assertion SHALL take effect immediately and asynchronously, including mid-period.
REQ-029 Deassertion SHALL be synchronised by the integrator; the block needs no internal synchroniser.
REQ-030 The first active edge after reset SHALL behave as IDLE or RUN according to en.

Configuration
REQ-031 With macro CLK_GEN_PHASE_SYNC_EN defined, the block SHALL add input port sync (input, 1 bit). sync high for one cycle forces every RUN channel to cnt=0 on the next cycle, applying any pending shadow, so that all channel edges realign. sync has priority over normal increment and wrap.
REQ-032 Without the macro, the sync port and its logic SHALL be absent, and the behaviour is exactly REQ-011..REQ-025.

Structure
REQ-033 Package clk_gen_pkg SHALL hold the default constants (NCH_DEF=4, W_DEF=16, P_MIN=2, H_RESET=1) and the channel state enumeration (IDLE, RUN).
REQ-034 Sub-module clk_gen_chan SHALL implement one channel (REQ-011..REQ-024).
REQ-035 The top SHALL instantiate NCH copies via generate and slice the period/high buses.

Verification
REQ-036 P=4, H=2, en rise: clk_out 1,1,0,0 repeating; tick on every 4th cycle, aligned with the last low cycle.
REQ-037 P=5, H=2: 2 high / 3 low; P=0 and P=1 behave as P=2, H=1.
REQ-038 Running P=8, H=4, load P=4, H=1 at cnt=2: the current period completes as 8 cycles, then the 4-cycle pattern 1,0,0,0 follows; no runt pulse.
REQ-039 H=0 gives clk_out stuck 0 and H=P=6 gives clk_out stuck 1, with tick every 6 cycles in both cases.
REQ-040 rst_n low at cnt=3 of P=8: outputs 0 immediately; after release with en=1, the sequence restarts at cnt=0 with P=2, H=1 until a load.
REQ-041 CLK_GEN_PHASE_SYNC_EN with ch0 P=4, ch1 P=6 running offset: pulse sync, and both channels show cnt=0 and clk_out rising on the same cycle.
